// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
//
// Player motion and animation controller. Converts held direction keys into
// the player's logical-screen position and sprite-sheet frame index. Motion is
// evaluated once per internal move tick, clamped to the 320x240 playfield, and
// the player is respawned every time a stage state is entered.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   state [3:0]   game state (TITLE=0 .. FAIL=8; STAGE1/2/3 = 2/4/6 are active)
//   key_up        held-level direction keys, already synchronous to clk
//   key_down
//   key_left
//   key_right
//   player_x [8:0]      sprite left edge, 0..X_MAX
//   player_y [8:0]      sprite top edge, 0..Y_MAX
//   player_state [3:0]  {dir[1:0], frame[1:0]}; dir 0=down 1=up 2=left 3=right
// -----------------------------------------------------------------------------
module player_ctrl #(
    parameter int CLK_DIV    = 1666666,  // clocks per move tick, >= 2
    parameter int STEP       = 1,        // pixels per move tick
    parameter int ANIM_TICKS = 8,        // move ticks per walk-frame advance
    parameter int X_MAX      = 310,
    parameter int Y_MAX      = 230,
    parameter int SPAWN_X    = 10,
    parameter int SPAWN_Y    = 110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic [8:0] player_x,
    output logic [8:0] player_y,
    output logic [3:0] player_state
);

    // Facing direction, encoded the way the sprite sheet orders its rows.
    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Only the three stage states allow movement.
    localparam logic [3:0] ST_STAGE1 = 4'd2;
    localparam logic [3:0] ST_STAGE2 = 4'd4;
    localparam logic [3:0] ST_STAGE3 = 4'd6;

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_TICKS - 1);

    // Position arithmetic runs at 10 bits so a step past 511 cannot wrap
    // before the clamp is applied.
    localparam logic [9:0] STEP_W  = 10'(STEP);
    localparam logic [8:0] STEP_N  = 9'(STEP);
    localparam logic [9:0] X_MAX_W = 10'(X_MAX);
    localparam logic [9:0] Y_MAX_W = 10'(Y_MAX);
    localparam logic [8:0] X_MAX_N = 9'(X_MAX);
    localparam logic [8:0] Y_MAX_N = 9'(Y_MAX);
    localparam logic [8:0] SPAWN_X_N = 9'(SPAWN_X);
    localparam logic [8:0] SPAWN_Y_N = 9'(SPAWN_Y);

    // ------------------------------------------------------------------
    // State registers and their next values
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt, tick_cnt_next;
    logic [AW-1:0] anim_cnt, anim_cnt_next;
    dir_e          dir, dir_next;
    logic [1:0]    frame, frame_next;
    logic [3:0]    prev_state;
    logic [8:0]    pos_x, pos_x_next;
    logic [8:0]    pos_y, pos_y_next;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic tick;
    logic active;
    logic entry;
    logic any_key;

    assign tick    = (tick_cnt == TICK_LAST);
    assign active  = (state == ST_STAGE1) || (state == ST_STAGE2) ||
                     (state == ST_STAGE3);
    // A change into an active state is an entry, including a return to the
    // same stage via any non-stage state.
    assign entry   = active && (state != prev_state);
    assign any_key = key_up | key_down | key_left | key_right;

    // ------------------------------------------------------------------
    // Clamped single-step candidates for each direction
    // ------------------------------------------------------------------
    logic [9:0] x_sum, y_sum;
    logic [8:0] x_left, x_right, y_up, y_down;

    assign x_sum   = {1'b0, pos_x} + STEP_W;
    assign y_sum   = {1'b0, pos_y} + STEP_W;
    assign x_left  = ({1'b0, pos_x} < STEP_W) ? 9'd0 : (pos_x - STEP_N);
    assign y_up    = ({1'b0, pos_y} < STEP_W) ? 9'd0 : (pos_y - STEP_N);
    assign x_right = (x_sum > X_MAX_W) ? X_MAX_N : x_sum[8:0];
    assign y_down  = (y_sum > Y_MAX_W) ? Y_MAX_N : y_sum[8:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        tick_cnt_next = tick ? '0 : (tick_cnt + TW'(1));
        anim_cnt_next = anim_cnt;
        dir_next      = dir;
        frame_next    = frame;
        pos_x_next    = pos_x;
        pos_y_next    = pos_y;

        if (entry) begin
            // Entry wins over a coincident tick and realigns the tick phase.
            tick_cnt_next = '0;
            anim_cnt_next = '0;
            dir_next      = DIR_DOWN;
            frame_next    = 2'd0;
            pos_x_next    = SPAWN_X_N;
            pos_y_next    = SPAWN_Y_N;
        end else if (active && tick) begin
            if (any_key) begin
                // Single winner, up > down > left > right. Direction still
                // updates when the player is pinned against a wall.
                if (key_up) begin
                    pos_y_next = y_up;
                    dir_next   = DIR_UP;
                end else if (key_down) begin
                    pos_y_next = y_down;
                    dir_next   = DIR_DOWN;
                end else if (key_left) begin
                    pos_x_next = x_left;
                    dir_next   = DIR_LEFT;
                end else begin
                    pos_x_next = x_right;
                    dir_next   = DIR_RIGHT;
                end

                if (anim_cnt == ANIM_LAST) begin
                    anim_cnt_next = '0;
                    frame_next    = frame + 2'd1;
                end else begin
                    anim_cnt_next = anim_cnt + AW'(1);
                end
            end else begin
                // Standing still shows the idle frame but keeps facing.
                anim_cnt_next = '0;
                frame_next    = 2'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            anim_cnt   <= '0;
            dir        <= DIR_DOWN;
            frame      <= 2'd0;
            prev_state <= 4'd0;
            pos_x      <= SPAWN_X_N;
            pos_y      <= SPAWN_Y_N;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            tick_cnt   <= tick_cnt_next;
            anim_cnt   <= anim_cnt_next;
            dir        <= dir_next;
            frame      <= frame_next;
            prev_state <= state;
            pos_x      <= pos_x_next;
            pos_y      <= pos_y_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (direct register taps)
    // ------------------------------------------------------------------
    assign player_x     = pos_x;
    assign player_y     = pos_y;
    assign player_state = {dir, frame};

endmodule
